// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the generic pipeline stage register:
//   - pipe_stage_state_e : occupancy state of a stage (EMPTY / ONE / TWO)
//   - RV_NOP             : RV32 canonical NOP (addi x0, x0, 0)
//   - if_id_payload_t    : IF/ID payload layout {pc_plus_4, instr}
//   - IF_ID_BUBBLE       : IF/ID payload presented by an empty stage
//   - occupancy_of()     : live-entry count for a given state
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_stage_state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] instr;
    } if_id_payload_t;

    // An empty IF/ID slot looks like a NOP fetched from pc 0, so any
    // downstream stage that ignores valid still executes something harmless.
    localparam if_id_payload_t IF_ID_BUBBLE = '{pc_plus_4: 32'h0, instr: RV_NOP};

    function automatic logic [1:0] occupancy_of(input pipe_stage_state_e s);
        logic [1:0] occ;
        case (s)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a configurable bubble payload.
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   : main + skid register, in_ready registered
//                                  (no combinational path from out_ready).
//   PIPE_STAGE_SKID_EN undefined : single main register,
//                                  in_ready = !out_valid | out_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      upstream offers in_data
//   in_ready   out  1      stage accepts in_data this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data is a live entry
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  payload to downstream (BUBBLE when not valid)
//   occupancy  out  2      live entries held (0..2)
// ----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(IF_ID_BUBBLE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_stage_state_e state_q;
    pipe_stage_state_e state_d;
    logic [WIDTH-1:0]  main_q;
    logic [WIDTH-1:0]  main_d;
    logic              out_valid_q;
    logic [1:0]        occupancy_q;
    logic              in_fire;
    logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0]  skid_q;
    logic [WIDTH-1:0]  skid_d;
    logic              in_ready_q;

    // in_ready is a registered decode of the next state, which is what lets
    // the skid register absorb the one entry that arrives while downstream
    // back-pressure propagates upstream.
    assign in_ready = in_ready_q;
`else
    // Without a skid slot the stage can only accept when its single entry is
    // leaving (or absent), so ready must follow out_ready combinationally.
    assign in_ready = !out_valid_q | out_ready;
`endif

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occupancy_q;

    // Next-state and payload steering. Flush wins over every handshake: an
    // incoming entry in the same cycle is dropped, and an entry leaving in the
    // same cycle has already been taken by downstream, so nothing is lost.
    // Whenever main empties it is reloaded with BUBBLE so out_data never
    // shows stale data while out_valid is low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = BUBBLE;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
`else
                    // In ONE, in_fire implies out_ready, so the entry in
                    // main is being replaced as it leaves.
                    if (in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
`endif
                end
                TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                    // in_ready is low here, so only a drain can happen; the
                    // older entry leaves and the skid entry moves up.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
`else
                    state_d = EMPTY;
                    main_d  = BUBBLE;
`endif
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers. The status outputs are decoded from the
    // next state so they are plain flops aligned with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= (state_d != EMPTY);
            occupancy_q <= occupancy_of(state_d);
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed and randomised stimulus for pipe_stage_reg, checked against a
// queue-based model of the stage: a FIFO of capacity 2 (skid build) or 1
// (no-skid build) that flush empties and reset clears immediately.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          WIDTH  = 64;
    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    logic [WIDTH-1:0] model_q[$];
    int               checks;
    int               errors;

    pipe_stage_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected readiness: skid stage accepts while it has a free slot; the
    // single-register stage accepts when empty or when its entry is leaving.
    function automatic logic modelInReady(input logic ordy);
        if (SKID)
            return (model_q.size() < 2);
        return (model_q.size() == 0) || ordy;
    endfunction

    task automatic checkOutput(input string tag, input logic ordy);
        logic             expValid;
        logic [WIDTH-1:0] expData;
        logic [1:0]       expOcc;
        logic             expReady;
        expValid = (model_q.size() != 0);
        expData  = expValid ? model_q[0] : BUBBLE;
        expOcc   = 2'(model_q.size());
        expReady = modelInReady(ordy);
        checks++;
        assert (out_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s.out_valid observed %b expected %b", tag, out_valid, expValid);
        end
        checks++;
        assert (out_data === expData) else begin
            errors++;
            $error("[TB] FAIL %s.out_data observed %h expected %h", tag, out_data, expData);
        end
        checks++;
        assert (occupancy === expOcc) else begin
            errors++;
            $error("[TB] FAIL %s.occupancy observed %0d expected %0d", tag, occupancy, expOcc);
        end
        checks++;
        assert (in_ready === expReady) else begin
            errors++;
            $error("[TB] FAIL %s.in_ready observed %b expected %b", tag, in_ready, expReady);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, check mid-low
    // phase, then advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic fl, output logic accepted);
        logic inFire;
        logic outFire;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        checkOutput(tag, ordy);
        inFire   = iv && modelInReady(ordy);
        outFire  = (model_q.size() != 0) && ordy;
        accepted = inFire && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (outFire) void'(model_q.pop_front());
            if (inFire) model_q.push_back(d);
        end
    endtask

    initial begin
        logic acc;
        logic cDone;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("idle", 1'b0, 64'h0, 1'b0, 1'b0, acc);
        applyStimulus("idle2", 1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Streaming with out_ready held high.
        for (int i = 1; i <= 8; i++)
            applyStimulus($sformatf("stream%0d", i), 1'b1, 64'(i), 1'b1, 1'b0, acc);
        applyStimulus("stream_drain", 1'b0, 64'h0, 1'b1, 1'b0, acc);
        applyStimulus("stream_empty", 1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Back-pressure: A, B, then C offered while downstream is stalled.
        applyStimulus("bp_a", 1'b1, 64'hA, 1'b0, 1'b0, acc);
        applyStimulus("bp_b", 1'b1, 64'hB, 1'b0, 1'b0, acc);
        cDone = 1'b0;
        applyStimulus("bp_c_held", 1'b1, 64'hC, 1'b0, 1'b0, acc);
        cDone = acc;
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("bp_drain%0d", i), !cDone, 64'hC, 1'b1, 1'b0, acc);
            cDone = cDone | acc;
        end

        // Flush while full, with D offered in the same cycle.
        applyStimulus("fl_a", 1'b1, 64'hA, 1'b0, 1'b0, acc);
        applyStimulus("fl_b", 1'b1, 64'hB, 1'b0, 1'b0, acc);
        applyStimulus("flush_d", 1'b1, 64'hD, 1'b0, 1'b1, acc);
        applyStimulus("after_flush", 1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Flush held for two cycles keeps the stage empty.
        applyStimulus("flush_hold1", 1'b1, 64'hE1, 1'b1, 1'b1, acc);
        applyStimulus("flush_hold2", 1'b1, 64'hE2, 1'b1, 1'b1, acc);
        applyStimulus("flush_resume", 1'b1, 64'hE3, 1'b0, 1'b0, acc);
        applyStimulus("flush_resume2", 1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset pulse between edges with the stage full.
        applyStimulus("ar_a", 1'b1, 64'h1111, 1'b0, 1'b0, acc);
        applyStimulus("ar_b", 1'b1, 64'h2222, 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        reset = 1'b1;
        model_q.delete();
        #1;
        checkOutput("async_reset", 1'b0);
        #1;
        reset = 1'b0;
        applyStimulus("post_reset", 1'b0, 64'h0, 1'b0, 1'b0, acc);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($sformatf("rand%0d", i),
                          1'($urandom_range(0, 3) != 0),
                          {$urandom(), $urandom()},
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0),
                          acc);
        end
        applyStimulus("final", 1'b0, 64'h0, 1'b1, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a configurable bubble payload. It is the generic successor to the fixed IF/ID register and sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure replaces the stall input. Flush squashes all held entries and presents a bubble.

## Interface
- WIDTH, 64, payload width in bits (IF/ID: {pc_plus_4, instr}).
- BUBBLE, {32'h0, 32'h00000013}, payload presented when empty, after reset and after flush (pc 0, RV32 NOP addi x0,x0,0).
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries; highest priority after reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a live entry.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload to downstream.
- occupancy  out  2  live entries held (0..2).

## Operation
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States: EMPTY (occ 0), ONE (main live), TWO (main and skid live).
- EMPTY: input fire -> ONE, main <= in_data.
- ONE, input fire and output fire -> ONE, main <= in_data.
- ONE, input fire only -> TWO, skid <= in_data.
- ONE, output fire only -> EMPTY, main <= BUBBLE.
- ONE, neither -> hold.
- TWO: in_ready = 0. Output fire -> ONE, main <= skid. Otherwise hold.
- in_ready = (state != TWO). It is a registered decode of state and has no combinational path from out_ready.
- flush: next state EMPTY, main <= BUBBLE, both valids cleared.
  - An input fire in the same cycle is discarded.
  - An output fire in the same cycle still counts as consumed by downstream.
- Payload is never modified. The order of entries is strictly FIFO.
- out_data == BUBBLE whenever out_valid == 0.

## Timing
- Reset values:
  - state EMPTY
  - out_valid 0
  - out_data BUBBLE
  - in_ready 1 (skid build) or 1 (no-skid build)
  - occupancy 0
- Latency: 1 cycle. in_data accepted at edge N appears on out_data after edge N with out_valid = 1.
- Throughput: 1 entry/cycle while out_ready = 1.
- A reset asserted mid-transfer drops every entry immediately, without waiting for a clock edge.
- A flush held for multiple cycles keeps the stage EMPTY. Acceptance resumes the cycle after flush deasserts.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid behaviour exactly as above; in_ready is registered.
- PIPE_STAGE_SKID_EN undefined: single main register, TWO state removed.
  - in_ready = !out_valid | out_ready, which is combinational from out_ready.
  - occupancy never exceeds 1.
  - Flush, BUBBLE and reset behaviour are unchanged.

## Structure
- Shared package pipe_pkg holds:
  - the state enum pipe_stage_state_e {EMPTY, ONE, TWO}
  - RV_NOP = 32'h00000013
  - the IF/ID payload struct if_id_payload_t {pc_plus_4[31:0], instr[31:0]}, used to build the default BUBBLE.
- Flat module with no sub-module. Each skid slot is only a register and a valid bit, so splitting it out adds nothing.

## Test plan
- Reset, then idle: out_valid = 0, out_data = 64'h0000_0000_0000_0013, in_ready = 1, occupancy = 0.
- Streaming: out_ready held 1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later each, no gaps, occupancy stays 1.
- Back-pressure (skid build):
  - Push 0xA then 0xB with out_ready = 0 -> occupancy 2, in_ready = 0, 0xC held off.
  - Raise out_ready -> 0xA, 0xB, 0xC delivered in order.
- Flush in TWO with in_valid = 1 (payload 0xD) -> next cycle out_valid = 0, out_data = BUBBLE, occupancy 0, and 0xD never appears.
- Asynchronous reset pulse between clock edges while occupancy = 2 -> outputs return to reset values before the next edge.
- No-skid build:
  - out_ready = 0 with a live entry -> in_ready = 0 in the same cycle.
  - out_ready = 1 -> in_ready = 1 in the same cycle, throughput 1/cycle.
